prog_delay_line: RTL and testbench

- Run-time programmable delay line for N-bit data gated by clock enable `ce`.
- Delay D is set per `ce` from 0 to MAX_DELAY samples.
- Implemented as a circular buffer: the write side stores each sample; the read side trails the write pointer by D-1 entries.
- Used where pipeline branches need alignment whose latency is only known at configuration time (e.g. switchable filter kernels). Replaces chains of fixed register stages.

---
 rtl/prog_delay_line.sv | 65 ++++++
 tb/tb_prog_delay_line.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/prog_delay_line.sv
// Run-time programmable delay line for ce-gated N-bit samples.
// A circular buffer with a trailing read tap replaces a chain of fixed register stages.
module prog_delay_line #(
  parameter int N = 8,
  parameter int MAX_DELAY = 16,
  localparam int AW = $clog2(MAX_DELAY),
  localparam int DW = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic [DW-1:0] delay,
  input  logic [N-1:0]  idata,
  output logic [N-1:0]  odata,
  output logic          ovalid
);

  localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
  localparam logic [AW-1:0] LAST  = AW'(MAX_DELAY - 1);
  localparam logic [AW:0]   DEPTH = (AW + 1)'(MAX_DELAY);

  logic [N-1:0]  mem [MAX_DELAY];
  logic [AW-1:0] wp_reg;
  logic [DW-1:0] cnt_reg;
  logic [N-1:0]  odata_reg;
  logic          ovalid_reg;

  logic [DW-1:0] de;
  logic [DW-1:0] cnt_next;
  logic [AW:0]   rd_sum;
  logic [AW-1:0] rd_addr;

  // Read tap trails wp by De-1 entries; one extra bit keeps the modulo subtraction positive.
  always_comb begin
    de       = (delay > MAX_D) ? MAX_D : delay;
    cnt_next = (cnt_reg == MAX_D) ? MAX_D : cnt_reg + 1'b1;
    rd_sum   = {1'b0, wp_reg} + DEPTH - (AW + 1)'(de) + 1'b1;
    rd_addr  = (rd_sum >= DEPTH) ? AW'(rd_sum - DEPTH) : AW'(rd_sum);
  end

  always_ff @(posedge clk) begin
    if (ce && !rst) begin
      mem[wp_reg] <= idata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_reg     <= '0;
      cnt_reg    <= '0;
      odata_reg  <= '0;
      ovalid_reg <= 1'b0;
    end else if (ce) begin
      wp_reg     <= (wp_reg == LAST) ? '0 : wp_reg + 1'b1;
      cnt_reg    <= cnt_next;
      // Short delays bypass the buffer; longer ones read old contents before this write lands.
      odata_reg  <= (de <= DW'(1)) ? idata : mem[rd_addr];
      ovalid_reg <= (cnt_next >= de);
    end
  end

  assign odata  = (de == '0) ? idata : odata_reg;
  assign ovalid = (de == '0) | ovalid_reg;

endmodule

// File: tb/tb_prog_delay_line.sv
// Bench for prog_delay_line: a constant vector table plus model-driven sequences,
// with expectations queued on drive and popped after the clock edge.
module tb_prog_delay_line;
  localparam int N  = 8;
  localparam int M  = 16;
  localparam int DW = $clog2(M + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ce;
  logic [DW-1:0] delay;
  logic [N-1:0]  idata;
  logic [N-1:0]  odata;
  logic          ovalid;

  always #5 clk = ~clk;

  prog_delay_line #(.N(N), .MAX_DELAY(M)) dut (
    .clk(clk), .rst(rst), .ce(ce), .delay(delay),
    .idata(idata), .odata(odata), .ovalid(ovalid)
  );

  typedef struct {
    logic [N-1:0] odata;
    logic         ovalid;
    bit           chk;
  } exp_t;

  typedef struct {
    bit           rst;
    bit           ce;
    int           delay;
    logic [N-1:0] idata;
    logic [N-1:0] odata;
    logic         ovalid;
    bit           chk;
  } vec_t;

  exp_t sb[$];
  vec_t tab[$];
  int total = 0;
  int bad   = 0;

  // Reference: full sample history plus count of samples accepted since reset.
  logic [N-1:0] hist[$];
  int           cnt_m   = 0;
  logic [N-1:0] m_odata = '0;
  logic         m_ovalid = 1'b0;
  bit           m_known = 1'b1;

  function automatic int eff(int d);
    return (d > M) ? M : d;
  endfunction

  task automatic step(bit r, bit c, int d, logic [N-1:0] x, string name,
                      bit use_tab = 1'b0, logic [N-1:0] t_od = '0,
                      logic t_ov = 1'b0, bit t_chk = 1'b0);
    exp_t e;
    exp_t got;
    int de;
    rst = r; ce = c; delay = DW'(d); idata = x;
    de = eff(d);
    if (r) begin
      cnt_m = 0; m_odata = '0; m_ovalid = 1'b0; m_known = 1'b1;
    end else if (c) begin
      hist.push_back(x);
      cnt_m++;
      m_ovalid = (cnt_m >= de);
      if (de == 0) begin
        m_known = 1'b0;
      end else if (m_ovalid) begin
        m_odata = hist[hist.size() - de];
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end
    if (use_tab) begin
      e.odata = t_od; e.ovalid = t_ov; e.chk = t_chk;
    end else if (de == 0) begin
      e.odata = x; e.ovalid = 1'b1; e.chk = 1'b1;
    end else begin
      e.odata = m_odata; e.ovalid = m_ovalid; e.chk = m_known;
    end
    sb.push_back(e);
    if (de == 0) begin
      #1;
      total++;
      if (odata !== x || ovalid !== 1'b1) begin
        bad++;
        $display("FAIL %s_bypass: odata=%0h ovalid=%0b expected odata=%0h ovalid=1",
                 name, odata, ovalid, x);
      end
    end
    @(posedge clk);
    #1;
    got = sb.pop_front();
    total++;
    if (ovalid !== got.ovalid || (got.chk && odata !== got.odata)) begin
      bad++;
      $display("FAIL %s: odata=%0h ovalid=%0b expected odata=%0h ovalid=%0b (data checked=%0b)",
               name, odata, ovalid, got.odata, got.ovalid, got.chk);
    end
  endtask

  initial begin
    int d;
    rst = 1'b1; ce = 1'b0; delay = '0; idata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, De=4 fill, 4->2 decrease, 2->8 increase, clamp of 31 to 16.
    tab.push_back('{1'b1, 1'b0, 4, 8'd0, 8'd0, 1'b0, 1'b1});
    for (int k = 1; k <= 10; k++)
      tab.push_back('{1'b0, 1'b1, 4, 8'(k), 8'(k - 3), (k >= 4), (k >= 4)});
    tab.push_back('{1'b0, 1'b1, 2, 8'd11, 8'd10, 1'b1, 1'b1});
    for (int k = 12; k <= 19; k++)
      tab.push_back('{1'b0, 1'b1, 2, 8'(k), 8'(k - 1), 1'b1, 1'b1});
    tab.push_back('{1'b0, 1'b1, 8, 8'd20, 8'd13, 1'b1, 1'b1});
    tab.push_back('{1'b0, 1'b1, 31, 8'd21, 8'd6, 1'b1, 1'b1});
    for (int i = 0; i < tab.size(); i++)
      step(tab[i].rst, tab[i].ce, tab[i].delay, tab[i].idata, "table", 1'b1,
           tab[i].odata, tab[i].ovalid, tab[i].chk);

    // De=1 then De=0, including bypass while reset is held.
    step(1'b1, 1'b0, 1, 8'h00, "rst_de1");
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1, 8'(i * 7), "de1");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, 8'($urandom), "de0");
    step(1'b1, 1'b0, 0, 8'hA5, "de0_rst");
    step(1'b0, 1'b1, 1, 8'h3C, "de1_after_rst");

    // Full-depth delay across several pointer wraps.
    step(1'b1, 1'b0, 16, 8'h00, "rst_de16");
    for (int i = 0; i <= 40; i++) step(1'b0, 1'b1, 16, 8'(i), "de16");

    // Clock-enable gating: ce pattern 1,0,0 repeating.
    step(1'b1, 1'b0, 4, 8'h00, "rst_ce");
    for (int i = 0; i < 40; i++) step(1'b0, (i % 3 == 0), 4, 8'($urandom), "ce_gate");

    // Reset in the middle of a De=3 stream, then refill with a,b,c.
    step(1'b1, 1'b0, 3, 8'h00, "rst_mid_pre");
    for (int k = 1; k <= 12; k++) step(1'b0, 1'b1, 3, 8'(k), "pre_rst");
    step(1'b1, 1'b1, 3, 8'h99, "mid_rst");
    step(1'b0, 1'b1, 3, 8'hA1, "refill_a");
    step(1'b0, 1'b1, 3, 8'hB2, "refill_b");
    step(1'b0, 1'b1, 3, 8'hC3, "refill_c", 1'b1, 8'hA1, 1'b1, 1'b1);

    // Random mix of ce, delay changes (including clamped values) and resets.
    d = 5;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) d = int'($urandom_range(0, 20));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), d,
           8'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
